// File: rtl/sa_latch_pkg.sv
// sa_latch_pkg
//   Shared definitions for the latch-array write path.
//   - state_t : sequencer state encoding (IDLE, OPEN, CLOSE), ST_W bits wide
//   - addr_w  : address width for a given entry count; a single entry still
//               gets a 1-bit address so that no port collapses to zero width
package sa_latch_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        CLOSE = 2'd2
    } state_t;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sa_onehot_dec.sv
// sa_onehot_dec
//   Binary index to one-hot decoder with an enable. Shared with the latch
//   array's read-mux select so both sides decode the index the same way.
// Ports
//   en      in   1      when low, all outputs are 0
//   addr    in   AW     entry index; indices >= DEPTH produce all zeros
//   onehot  out  DEPTH  one-hot select
module sa_onehot_dec
    import sa_latch_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic             en,
    input  logic [AW-1:0]    addr,
    output logic [DEPTH-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            onehot[i] = en && (addr == AW'(i));
        end
    end

endmodule

// File: rtl/sa_latch_wr_seq.sv
// sa_latch_wr_seq
//   Write sequencer for an array of negedge-EN capture latches. Each accepted
//   request becomes an OPEN cycle (D driven, one EN high) followed by a CLOSE
//   cycle (EN low, D held), so D is stable on both sides of every EN fall.
// Ports
//   clk       in   1      clock, all logic on posedge
//   rst       in   1      synchronous active-high reset
//   wr_valid  in   1      write request valid
//   wr_ready  out  1      request accepted on wr_valid & wr_ready at posedge
//   wr_addr   in   AW     target entry index
//   wr_data   in   WIDTH  data to store
//   lat_d     out  WIDTH  shared D bus to every latch cell
//   lat_en    out  DEPTH  one-hot EN strobes, capture on 1->0
//   busy      out  1      sequence in flight (state != IDLE)
//   wr_done   out  1      pulse in the cycle after CLOSE (data committed)
//   wr_err    out  1      pulse after accepting an out-of-range address
module sa_latch_wr_seq
    import sa_latch_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 8,
    localparam int AW    = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] lat_d,
    output logic [DEPTH-1:0] lat_en,
    output logic             busy,
    output logic             wr_done,
    output logic             wr_err
);

    // One extra bit so the range check also works when DEPTH is a power of two.
    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    state_t           state;
    state_t           state_n;
    logic [AW-1:0]    addr_q;
    logic [WIDTH-1:0] data_q;
    logic             done_q;
    logic             err_q;
    logic             accept;
    logic             legal;
    logic             load;
    logic             err_n;

    assign legal = ({1'b0, wr_addr} < DEPTH_LIM);

    // wr_ready depends on state (and reset) only, never on wr_valid.
    always_comb begin
        state_n  = state;
        wr_ready = 1'b0;
        load     = 1'b0;
        err_n    = 1'b0;
        accept   = 1'b0;

        if (!rst && (state == IDLE || state == CLOSE)) begin
            wr_ready = 1'b1;
        end
        accept = wr_valid && wr_ready;
        err_n  = accept && !legal;

        case (state)
            IDLE: begin
                if (accept && legal) begin
                    state_n = OPEN;
                    load    = 1'b1;
                end
            end
            OPEN: begin
                state_n = CLOSE;
            end
            CLOSE: begin
                if (accept && legal) begin
                    state_n = OPEN;
                    load    = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // The holding register is the D bus itself, so new data reaches lat_d on
    // the same edge that enters OPEN and stays put through CLOSE. On reset the
    // bus is only cleared when no EN is high; if reset lands in OPEN the EN
    // falls on that edge and D must still meet the latch hold time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (lat_en == '0) begin
                data_q <= '0;
                addr_q <= '0;
            end
        end else begin
            state  <= state_n;
            done_q <= (state == CLOSE);
            err_q  <= err_n;
            if (load) begin
                addr_q <= wr_addr;
                data_q <= wr_data;
            end
        end
    end

    sa_onehot_dec #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dec (
        .en     (state == OPEN),
        .addr   (addr_q),
        .onehot (lat_en)
    );

    assign lat_d   = data_q;
    assign busy    = (state != IDLE);
    assign wr_done = done_q;
    assign wr_err  = err_q;

endmodule

// File: tb/tb_sa_latch_wr_seq.sv
// tb_sa_latch_wr_seq
//   Directed bench for sa_latch_wr_seq. An 8-entry instance carries the main
//   traffic; a 6-entry instance exercises the out-of-range address handling.
//   A behavioural negedge-EN latch model sits on each lat_d/lat_en pair.
module tb_sa_latch_wr_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] lat_d;
    logic [7:0]  lat_en;
    logic        busy;
    logic        wr_done;
    logic        wr_err;

    logic        v6;
    logic        rdy6;
    logic [2:0]  a6;
    logic [31:0] d6;
    logic [31:0] lat_d6;
    logic [5:0]  lat_en6;
    logic        busy6;
    logic        done6;
    logic        err6;

    int errors = 0;
    int checks = 0;

    sa_latch_wr_seq #(.WIDTH(32), .DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .lat_d    (lat_d),
        .lat_en   (lat_en),
        .busy     (busy),
        .wr_done  (wr_done),
        .wr_err   (wr_err)
    );

    sa_latch_wr_seq #(.WIDTH(32), .DEPTH(6)) dut6 (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (v6),
        .wr_ready (rdy6),
        .wr_addr  (a6),
        .wr_data  (d6),
        .lat_d    (lat_d6),
        .lat_en   (lat_en6),
        .busy     (busy6),
        .wr_done  (done6),
        .wr_err   (err6)
    );

    // Latch array model plus invariant monitors. Sampled at posedge, so the
    // values seen are those of the cycle that is just ending.
    logic [31:0] mem  [8];
    logic [31:0] mem6 [6];
    logic [7:0]  prev_en  = '0;
    logic [31:0] prev_d   = '0;
    logic [5:0]  prev_en6 = '0;
    logic [31:0] prev_d6  = '0;
    int cap_cnt    = 0;
    int cap6_cnt   = 0;
    int done_cnt   = 0;
    int viol_multi = 0;
    int viol_d     = 0;

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        for (int i = 0; i < 6; i++) mem6[i] = '0;
    end

    always @(posedge clk) begin
        if (!$onehot0(lat_en))  viol_multi++;
        if (!$onehot0(lat_en6)) viol_multi++;
        if (prev_en  != '0 && lat_d  !== prev_d)  viol_d++;
        if (prev_en6 != '0 && lat_d6 !== prev_d6) viol_d++;
        for (int i = 0; i < 8; i++) begin
            if (prev_en[i] && !lat_en[i]) begin
                mem[i] = prev_d;
                cap_cnt++;
            end
        end
        for (int i = 0; i < 6; i++) begin
            if (prev_en6[i] && !lat_en6[i]) begin
                mem6[i] = prev_d6;
                cap6_cnt++;
            end
        end
        if (wr_done) done_cnt++;
        prev_en  = lat_en;
        prev_d   = lat_d;
        prev_en6 = lat_en6;
        prev_d6  = lat_d6;
    end

    task automatic applyStimulus(input logic v, input logic [2:0] a, input logic [31:0] d);
        wr_valid = v;
        wr_addr  = a;
        wr_data  = d;
    endtask

    task automatic applyStimulus6(input logic v, input logic [2:0] a, input logic [31:0] d);
        v6 = v;
        a6 = a;
        d6 = d;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int guard;
        int done_base;
        int cap_base;

        // Reset with random inputs for three cycles
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
            applyStimulus6(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
            @(negedge clk);
        end
        checkOutput("rst_lat_en",  lat_en,   8'h00);
        checkOutput("rst_busy",    busy,     1'b0);
        checkOutput("rst_ready",   wr_ready, 1'b0);
        checkOutput("rst_lat_d",   lat_d,    32'h0);
        checkOutput("rst_done",    wr_done,  1'b0);
        checkOutput("rst_err",     wr_err,   1'b0);
        checkOutput("rst_lat_en6", lat_en6,  6'h00);
        checkOutput("rst_lat_d6",  lat_d6,   32'h0);
        rst = 1'b0;
        applyStimulus(1'b0, 3'd0, 32'h0);
        applyStimulus6(1'b0, 3'd0, 32'h0);
        @(negedge clk);
        checkOutput("idle_ready", wr_ready, 1'b1);
        checkOutput("idle_busy",  busy,     1'b0);

        // Single write: addr 3, 0xDEADBEEF
        applyStimulus(1'b1, 3'd3, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("w1_en_open",    lat_en,   8'h08);
        checkOutput("w1_d_open",     lat_d,    32'hDEADBEEF);
        checkOutput("w1_busy_open",  busy,     1'b1);
        checkOutput("w1_ready_open", wr_ready, 1'b0);
        checkOutput("w1_done_open",  wr_done,  1'b0);
        applyStimulus(1'b0, 3'd0, 32'h0);
        @(negedge clk);
        checkOutput("w1_en_close",    lat_en,   8'h00);
        checkOutput("w1_d_close",     lat_d,    32'hDEADBEEF);
        checkOutput("w1_ready_close", wr_ready, 1'b1);
        checkOutput("w1_done_close",  wr_done,  1'b0);
        @(negedge clk);
        checkOutput("w1_done",     wr_done, 1'b1);
        checkOutput("w1_busy_end", busy,    1'b0);
        checkOutput("w1_mem3",     mem[3],  32'hDEADBEEF);
        @(negedge clk);
        checkOutput("w1_done_gone", wr_done, 1'b0);

        // Streaming writes to entries 0..7
        cyc       = 0;
        done_base = done_cnt;
        cap_base  = cap_cnt;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 3'(i), 32'(i * 32'h11));
            guard = 0;
            while (!wr_ready && guard < 8) begin
                @(negedge clk);
                cyc++;
                guard++;
            end
            checkOutput("stream_ready", wr_ready, 1'b1);
            @(negedge clk);
            cyc++;
        end
        applyStimulus(1'b0, 3'd0, 32'h0);
        checkOutput("stream_cycles", 64'(cyc), 64'd15);
        repeat (3) @(negedge clk);
        checkOutput("stream_dones", 64'(done_cnt - done_base), 64'd8);
        checkOutput("stream_caps",  64'(cap_cnt - cap_base),   64'd8);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("stream_mem%0d", i), mem[i], 64'(i * 32'h11));
        end
        checkOutput("stream_multihot", 64'(viol_multi), 64'd0);
        checkOutput("stream_d_change", 64'(viol_d),     64'd0);

        // Six-entry instance: last legal entry, then illegal from CLOSE and IDLE
        applyStimulus6(1'b1, 3'd5, 32'h00000055);
        @(negedge clk);
        checkOutput("d6_en_open", lat_en6, 6'h20);
        checkOutput("d6_busy",    busy6,   1'b1);
        applyStimulus6(1'b1, 3'd7, 32'hCAFEF00D);
        @(negedge clk);
        checkOutput("d6_en_close",  lat_en6, 6'h00);
        checkOutput("d6_err_close", err6,    1'b0);
        @(negedge clk);
        checkOutput("d6_err_pulse",  err6,    1'b1);
        checkOutput("d6_err_en",     lat_en6, 6'h00);
        checkOutput("d6_err_busy",   busy6,   1'b0);
        checkOutput("d6_err_d_held", lat_d6,  32'h00000055);
        checkOutput("d6_done",       done6,   1'b1);
        applyStimulus6(1'b1, 3'd6, 32'h12345678);
        @(negedge clk);
        checkOutput("d6_err_idle",    err6,    1'b1);
        checkOutput("d6_err_idle_en", lat_en6, 6'h00);
        checkOutput("d6_idle_busy",   busy6,   1'b0);
        applyStimulus6(1'b0, 3'd0, 32'h0);
        @(negedge clk);
        checkOutput("d6_err_gone", err6,    1'b0);
        checkOutput("d6_en_quiet", lat_en6, 6'h00);
        @(negedge clk);
        checkOutput("d6_caps", 64'(cap6_cnt), 64'd1);
        checkOutput("d6_mem5", mem6[5],       32'h00000055);

        // Reset while OPEN for addr 2
        applyStimulus(1'b1, 3'd2, 32'h5A5A5A5A);
        @(negedge clk);
        checkOutput("rm_en_open", lat_en, 8'h04);
        rst = 1'b1;
        applyStimulus(1'b0, 3'd0, 32'h0);
        @(negedge clk);
        checkOutput("rm_en_low", lat_en,   8'h00);
        checkOutput("rm_d_held", lat_d,    32'h5A5A5A5A);
        checkOutput("rm_busy",   busy,     1'b0);
        checkOutput("rm_ready",  wr_ready, 1'b0);
        checkOutput("rm_done0",  wr_done,  1'b0);
        done_base = done_cnt;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rm_done1", wr_done, 1'b0);
        @(negedge clk);
        checkOutput("rm_done2",    wr_done,                     1'b0);
        checkOutput("rm_no_dones", 64'(done_cnt - done_base),   64'd0);
        checkOutput("rm_mem2",     mem[2],                      32'h5A5A5A5A);
        checkOutput("rm_d_after",  lat_d,                       32'h5A5A5A5A);

        // Back-to-back writes to the same entry
        cap_base = cap_cnt;
        applyStimulus(1'b1, 3'd1, 32'h00000001);
        @(negedge clk);
        checkOutput("bb_en_a", lat_en, 8'h02);
        checkOutput("bb_d_a",  lat_d,  32'h00000001);
        applyStimulus(1'b1, 3'd1, 32'h00000002);
        @(negedge clk);
        checkOutput("bb_en_close", lat_en, 8'h00);
        checkOutput("bb_d_close",  lat_d,  32'h00000001);
        @(negedge clk);
        checkOutput("bb_en_b", lat_en, 8'h02);
        checkOutput("bb_d_b",  lat_d,  32'h00000002);
        applyStimulus(1'b0, 3'd0, 32'h0);
        repeat (3) @(negedge clk);
        checkOutput("bb_caps",      64'(cap_cnt - cap_base), 64'd2);
        checkOutput("bb_mem1",      mem[1],                  32'h00000002);
        checkOutput("all_multihot", 64'(viol_multi),         64'd0);
        checkOutput("all_d_change", 64'(viol_d),             64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
